velocity_broadcast_dispatcher: RTL

Transmitter side of the motion-update broadcast bus. It walks every source cell's double-buffered velocity cache in turn and reads the particle count at address 0, then each particle at addresses 1..N. Each returned velocity word is broadcast with its destination cell ID to all cell caches. It owns `motion_update_enable` for the whole system: raised at the start of the sweep, dropped after the last valid beat, so every receiving cache commits its count and swaps buffers.

---
 rtl/velocity_broadcast_dispatcher_if.sv | 35 +++
 rtl/velocity_broadcast_dispatcher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/velocity_broadcast_dispatcher_if.sv
// Bus bundle between the broadcast dispatcher, the cache read mux
// and the motion-update broadcast fabric.
interface velocity_broadcast_dispatcher_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CELL_ID_WIDTH  = 4,
    parameter int CELL_SEL_WIDTH = 6
);
    logic                         in_start;
    logic [3*DATA_WIDTH-1:0]      in_rd_data;
    logic [3*CELL_ID_WIDTH-1:0]   in_rd_dst_cell;
    logic [CELL_SEL_WIDTH-1:0]    out_cell_sel;
    logic [ADDR_WIDTH-1:0]        out_read_address;
    logic                         out_rden;
    logic                         out_motion_update_enable;
    logic [3*DATA_WIDTH-1:0]      out_data;
    logic [3*CELL_ID_WIDTH-1:0]   out_data_dst_cell;
    logic                         out_data_valid;
    logic                         out_busy;
    logic                         out_done;

    modport slave (
        input  in_start, in_rd_data, in_rd_dst_cell,
        output out_cell_sel, out_read_address, out_rden,
        output out_motion_update_enable, out_data, out_data_dst_cell,
        output out_data_valid, out_busy, out_done
    );

    modport master (
        output in_start, in_rd_data, in_rd_dst_cell,
        input  out_cell_sel, out_read_address, out_rden,
        input  out_motion_update_enable, out_data, out_data_dst_cell,
        input  out_data_valid, out_busy, out_done
    );
endinterface

// File: rtl/velocity_broadcast_dispatcher.sv
// Sweeps every source cell cache and broadcasts its velocities; define
// VELOCITY_BROADCAST_OUTREG_EN for an extra output register stage.
module velocity_broadcast_dispatcher #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CELL_ID_WIDTH  = 4,
    parameter int NUM_CELLS      = 36,
    parameter int CELL_SEL_WIDTH = 6
) (
    input  logic clk,
    input  logic rst,
    velocity_broadcast_dispatcher_if.slave bus
);

    localparam int VW = 3 * DATA_WIDTH;
    localparam int CW = 3 * CELL_ID_WIDTH;
`ifdef VELOCITY_BROADCAST_OUTREG_EN
    localparam logic [1:0] FLUSH_END = 2'd1;
`else
    localparam logic [1:0] FLUSH_END = 2'd0;
`endif

    typedef enum logic [2:0] {
        IDLE, READ_COUNT, WAIT_COUNT, STREAM, DRAIN, FLUSH, SETTLE
    } state_e;

    state_e                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [CELL_SEL_WIDTH-1:0] sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]     n_q, n_d;
    logic [ADDR_WIDTH-1:0]     rd_count;
    logic                      cell_end;
    logic                      last_cell;
    logic                      issue;

    logic [1:0]                fly_q;
    logic                      vld_q;
    logic [VW-1:0]             data_q;
    logic [CW-1:0]             dst_q;
    logic                      pipe_vld;

    assign rd_count  = bus.in_rd_data[ADDR_WIDTH-1:0];
    assign last_cell = (sel_q == CELL_SEL_WIDTH'(NUM_CELLS - 1));
    assign issue     = (state_q == STREAM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        n_d      = n_q;
        cell_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_start) begin
                    sel_d   = '0;
                    state_d = READ_COUNT;
                end
            end
            READ_COUNT: begin
                cnt_d   = '0;
                state_d = WAIT_COUNT;
            end
            WAIT_COUNT: begin
                if (cnt_q == 2'd0) begin
                    cnt_d = 2'd1;
                end else begin
                    n_d = rd_count;
                    if (rd_count == '0) begin
                        cell_end = 1'b1;
                    end else begin
                        addr_d  = ADDR_WIDTH'(1);
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                // stop on equality so N = all-ones never needs a wrap
                if (addr_q == n_q) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == 2'd0) cnt_d = 2'd1;
                else cell_end = 1'b1;
            end
            FLUSH: begin
                if (cnt_q == FLUSH_END) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == 2'd2) state_d = IDLE;
                else cnt_d = cnt_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
        // next-cell decision costs no cycle of its own
        if (cell_end) begin
            if (last_cell) begin
                cnt_d   = '0;
                state_d = FLUSH;
            end else begin
                sel_d   = sel_q + CELL_SEL_WIDTH'(1);
                state_d = READ_COUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fly_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            dst_q  <= '0;
        end else begin
            fly_q  <= {fly_q[0], issue};
            vld_q  <= fly_q[1];
            data_q <= fly_q[1] ? bus.in_rd_data : '0;
            dst_q  <= fly_q[1] ? bus.in_rd_dst_cell : '0;
        end
    end

`ifdef VELOCITY_BROADCAST_OUTREG_EN
    logic          o_vld_q;
    logic [VW-1:0] o_data_q;
    logic [CW-1:0] o_dst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
            o_dst_q  <= '0;
        end else begin
            o_vld_q  <= vld_q;
            o_data_q <= data_q;
            o_dst_q  <= dst_q;
        end
    end

    assign pipe_vld              = vld_q | o_vld_q;
    assign bus.out_data          = o_data_q;
    assign bus.out_data_dst_cell = o_dst_q;
    assign bus.out_data_valid    = o_vld_q;
`else
    assign pipe_vld              = vld_q;
    assign bus.out_data          = data_q;
    assign bus.out_data_dst_cell = dst_q;
    assign bus.out_data_valid    = vld_q;
`endif

    assign bus.out_cell_sel     = sel_q;
    assign bus.out_rden         = (state_q == READ_COUNT) || issue;
    assign bus.out_read_address = issue ? addr_q : '0;
    assign bus.out_busy         = (state_q != IDLE);
    assign bus.out_done         = (state_q == SETTLE) && (cnt_q == 2'd2);
    // window stays open in FLUSH only while beats are still leaving
    assign bus.out_motion_update_enable =
        (state_q == READ_COUNT) || (state_q == WAIT_COUNT) ||
        (state_q == STREAM) || (state_q == DRAIN) ||
        ((state_q == FLUSH) && pipe_vld);

endmodule
